// File: rtl/spi_minion_rr_arbiter.sv
// spi_minion_rr_arbiter
// Lets several on-chip requesters share one SPI minion adapter. The forward
// path picks a requester round-robin, tags its payload with the requester id,
// and holds it in a one-entry output register facing the adapter. The return
// path steers adapter responses back to requesters by that id field. Responses
// whose id maps to no requester are sunk and counted.
module spi_minion_rr_arbiter #(
    parameter int  nbits    = 8,
    parameter int  num_reqs = 4,
    localparam int MW       = nbits - 2,
    localparam int AW       = $clog2(num_reqs),
    localparam int PW       = MW - AW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [num_reqs-1:0]    req_val,
    output logic [num_reqs-1:0]    req_rdy,
    input  logic [num_reqs*PW-1:0] req_msg,
    output logic [MW-1:0]          adp_recv_msg,
    output logic                   adp_recv_val,
    input  logic                   adp_recv_rdy,
    input  logic [MW-1:0]          adp_send_msg,
    input  logic                   adp_send_val,
    output logic                   adp_send_rdy,
    output logic [num_reqs-1:0]    resp_val,
    input  logic [num_reqs-1:0]    resp_rdy,
    output logic [num_reqs*PW-1:0] resp_msg,
    output logic [AW-1:0]          grant_id,
    output logic [7:0]             drop_count
);

    // Forward-path state: output register and round-robin pointer.
    logic                out_val;
    logic [MW-1:0]       out_msg;
    logic [AW-1:0]       rr_ptr;

    // Arbiter results.
    logic [num_reqs-1:0] grant;
    logic [AW-1:0]       grant_idx;
    logic [PW-1:0]       grant_pay;
    logic                any_grant;
    logic                load_ok;
    int                  scan_dist;
    int                  best_dist;

    // Return-path decode.
    logic [AW-1:0]       send_id;
    logic [PW-1:0]       send_pay;
    logic                send_id_ok;

    // Round-robin pick: the valid requester closest to rr_ptr going upward, modulo num_reqs.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path can infer a latch.
        grant     = '0;
        grant_idx = '0;
        grant_pay = '0;
        any_grant = 1'b0;
        best_dist = num_reqs;
        scan_dist = 0;
        for (int i = 0; i < num_reqs; i++) begin
            scan_dist = (i - int'(rr_ptr) + num_reqs) % num_reqs;
            if (req_val[i] && (scan_dist < best_dist)) begin
                best_dist = scan_dist;
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = AW'(i);
                grant_pay = req_msg[i*PW +: PW];
                any_grant = 1'b1;
            end
        end
    end

    // The register can accept a new message when it is empty or being drained now.
    assign load_ok = ~out_val | adp_recv_rdy;
    assign req_rdy = {num_reqs{load_ok}} & grant;

    // Output register: load the granted message, otherwise drain on the adapter handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_val <= 1'b0;
            out_msg <= '0;
            rr_ptr  <= '0;
        end else if (any_grant && load_ok) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            out_val <= 1'b1;
            out_msg <= {grant_idx, grant_pay};
            rr_ptr  <= (grant_idx == AW'(num_reqs - 1)) ? '0 : grant_idx + AW'(1);
        end else if (out_val && adp_recv_rdy) begin
            out_val <= 1'b0;
        end
    end

    assign adp_recv_val = out_val;
    assign adp_recv_msg = out_msg;
    assign grant_id     = out_msg[MW-1 -: AW];

    // Split the returning message into its requester id and payload.
    assign send_id    = adp_send_msg[MW-1 -: AW];
    assign send_pay   = adp_send_msg[PW-1:0];
    assign send_id_ok = (int'(send_id) < num_reqs);

    // Return demux: steer to the addressed lane; unknown ids are sunk (always ready).
    always_comb begin
        resp_val     = '0;
        resp_msg     = '0;
        adp_send_rdy = 1'b1;
        for (int i = 0; i < num_reqs; i++) begin
            if (send_id_ok && (send_id == AW'(i))) begin
                resp_val[i]  = adp_send_val;
                adp_send_rdy = resp_rdy[i];
                if (adp_send_val) begin
                    resp_msg[i*PW +: PW] = send_pay;
                end
            end
        end
    end

    // Saturating count of returns addressed to a non-existent requester.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= 8'd0;
        end else if (adp_send_val && !send_id_ok && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_spi_minion_rr_arbiter.sv
// Testbench for spi_minion_rr_arbiter: a 4-requester and a 3-requester
// instance share one stimulus stream and are compared each cycle against a
// transaction-level model of arbitration, the output register and the return demux.
module tb_spi_minion_rr_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Shared stimulus.
    logic [3:0]  s_req_val;
    logic [15:0] s_req_msg;
    logic        s_recv_rdy;
    logic [5:0]  s_send_msg;
    logic        s_send_val;
    logic [3:0]  s_resp_rdy;

    // 4-requester instance outputs.
    logic [3:0]  r4_rdy;
    logic [5:0]  a4_msg;
    logic        a4_val;
    logic        a4_srdy;
    logic [3:0]  s4_val;
    logic [15:0] s4_msg;
    logic [1:0]  g4;
    logic [7:0]  d4;

    // 3-requester instance outputs.
    logic [2:0]  r3_rdy;
    logic [5:0]  a3_msg;
    logic        a3_val;
    logic        a3_srdy;
    logic [2:0]  s3_val;
    logic [11:0] s3_msg;
    logic [1:0]  g3;
    logic [7:0]  d3;

    spi_minion_rr_arbiter #(.nbits(8), .num_reqs(4)) dut4 (
        .clk(clk), .reset(reset),
        .req_val(s_req_val), .req_rdy(r4_rdy), .req_msg(s_req_msg),
        .adp_recv_msg(a4_msg), .adp_recv_val(a4_val), .adp_recv_rdy(s_recv_rdy),
        .adp_send_msg(s_send_msg), .adp_send_val(s_send_val), .adp_send_rdy(a4_srdy),
        .resp_val(s4_val), .resp_rdy(s_resp_rdy), .resp_msg(s4_msg),
        .grant_id(g4), .drop_count(d4)
    );

    spi_minion_rr_arbiter #(.nbits(8), .num_reqs(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_val(s_req_val[2:0]), .req_rdy(r3_rdy), .req_msg(s_req_msg[11:0]),
        .adp_recv_msg(a3_msg), .adp_recv_val(a3_val), .adp_recv_rdy(s_recv_rdy),
        .adp_send_msg(s_send_msg), .adp_send_val(s_send_val), .adp_send_rdy(a3_srdy),
        .resp_val(s3_val), .resp_rdy(s_resp_rdy[2:0]), .resp_msg(s3_msg),
        .grant_id(g3), .drop_count(d3)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Abstract state: is a message held, whose and what, who is next in line, drops seen.
    typedef struct packed {
        logic       val;
        logic [1:0] id;
        logic [3:0] pay;
        logic [1:0] ptr;
        logic [7:0] drop;
    } model_t;

    model_t m4, m3;

    // First valid requester in the order ptr, ptr+1, ... mod n; -1 if none.
    function automatic int exp_grant(int n, logic [1:0] ptr, logic [3:0] v);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (int'(ptr) + k) % n;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_req_rdy(int n, model_t m, logic [3:0] v, logic rdy);
        int g;
        g = exp_grant(n, m.ptr, v);
        if (g >= 0 && (!m.val || rdy)) return 4'(1 << g);
        return 4'b0;
    endfunction

    function automatic logic [3:0] exp_resp_val(int n, logic [5:0] sm, logic sv);
        int id;
        id = int'(sm[5:4]);
        if (id < n && sv) return 4'(1 << id);
        return 4'b0;
    endfunction

    function automatic logic exp_send_rdy(int n, logic [5:0] sm, logic [3:0] rr);
        int id;
        id = int'(sm[5:4]);
        if (id < n) return rr[id];
        return 1'b1;
    endfunction

    function automatic logic [15:0] exp_resp_msg(int n, logic [5:0] sm, logic sv);
        int id;
        id = int'(sm[5:4]);
        if (id < n && sv) return 16'(sm[3:0]) << (4 * id);
        return 16'h0;
    endfunction

    function automatic model_t model_next(int n, model_t m, logic [3:0] v, logic [15:0] msgs,
                                          logic rdy, logic [5:0] sm, logic sv);
        model_t nx;
        int     g;
        nx = m;
        g  = exp_grant(n, m.ptr, v);
        if (g >= 0 && (!m.val || rdy)) begin
            nx.val = 1'b1;
            nx.id  = 2'(g);
            nx.pay = msgs[4*g +: 4];
            nx.ptr = 2'((g + 1) % n);
        end else if (m.val && rdy) begin
            nx.val = 1'b0;
        end
        if (sv && int'(sm[5:4]) >= n && nx.drop != 8'd255) nx.drop = nx.drop + 8'd1;
        return nx;
    endfunction

    task automatic check_regs();
        check("recv_val4", 32'(a4_val), 32'(m4.val));
        check("recv_msg4", 32'(a4_msg), 32'({m4.id, m4.pay}));
        check("grant_id4", 32'(g4),     32'(m4.id));
        check("drop4",     32'(d4),     32'(m4.drop));
        check("recv_val3", 32'(a3_val), 32'(m3.val));
        check("recv_msg3", 32'(a3_msg), 32'({m3.id, m3.pay}));
        check("grant_id3", 32'(g3),     32'(m3.id));
        check("drop3",     32'(d3),     32'(m3.drop));
    endtask

    // One clock: check combinational outputs, advance model across the edge, check registers.
    task automatic cycle();
        model_t n4, n3;
        logic [3:0]  v3;
        logic [15:0] msg3;
        v3   = {1'b0, s_req_val[2:0]};
        msg3 = {4'b0, s_req_msg[11:0]};
        #1;
        check("req_rdy4",  32'(r4_rdy),  32'(exp_req_rdy(4, m4, s_req_val, s_recv_rdy)));
        check("req_rdy3",  32'(r3_rdy),  32'(exp_req_rdy(3, m3, v3, s_recv_rdy)));
        check("resp_val4", 32'(s4_val),  32'(exp_resp_val(4, s_send_msg, s_send_val)));
        check("resp_val3", 32'(s3_val),  32'(exp_resp_val(3, s_send_msg, s_send_val)));
        check("resp_msg4", 32'(s4_msg),  32'(exp_resp_msg(4, s_send_msg, s_send_val)));
        check("resp_msg3", 32'(s3_msg),  32'(exp_resp_msg(3, s_send_msg, s_send_val)));
        check("send_rdy4", 32'(a4_srdy), 32'(exp_send_rdy(4, s_send_msg, s_resp_rdy)));
        check("send_rdy3", 32'(a3_srdy), 32'(exp_send_rdy(3, s_send_msg, {1'b0, s_resp_rdy[2:0]})));
        n4 = model_next(4, m4, s_req_val, s_req_msg, s_recv_rdy, s_send_msg, s_send_val);
        n3 = model_next(3, m3, v3, msg3, s_recv_rdy, s_send_msg, s_send_val);
        @(posedge clk);
        #1;
        m4 = n4;
        m3 = n3;
        check_regs();
    endtask

    task automatic randomize_inputs();
        s_req_val  = 4'($urandom);
        s_req_msg  = 16'($urandom);
        s_recv_rdy = ($urandom_range(0, 3) != 0);
        s_send_msg = 6'($urandom);
        s_send_val = 1'($urandom);
        s_resp_rdy = 4'($urandom);
    endtask

    initial begin
        reset      = 1'b0;
        s_req_val  = '0;
        s_req_msg  = '0;
        s_recv_rdy = 1'b0;
        s_send_msg = '0;
        s_send_val = 1'b0;
        s_resp_rdy = '0;
        m4         = '0;
        m3         = '0;

        // Reset state.
        #12;
        check_regs();
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic on both paths.
        repeat (300) begin
            randomize_inputs();
            cycle();
        end

        // Reset mid-transfer: hold a message, then pulse reset between edges.
        s_req_val  = 4'hF;
        s_recv_rdy = 1'b0;
        s_send_val = 1'b0;
        cycle();
        cycle();
        check("mid_xfer_val", 32'(a4_val), 32'(1));
        #2 reset = 1'b0;
        #1;
        check("rst_now_val4",  32'(a4_val), 32'(0));
        check("rst_now_msg4",  32'(a4_msg), 32'(0));
        check("rst_now_grant", 32'(g4),     32'(0));
        check("rst_now_val3",  32'(a3_val), 32'(0));
        check("rst_now_drop3", 32'(d3),     32'(0));
        m4 = '0;
        m3 = '0;
        #1 reset = 1'b1;

        // All requesters valid with the adapter always ready: strict rotation from req0.
        s_recv_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_req_msg = 16'($urandom);
            cycle();
            check("rr_seq_id",  32'(g4),     32'(k % 4));
            check("rr_seq_val", 32'(a4_val), 32'(1));
        end

        // Stall: message from req2 must hold while the adapter is not ready.
        s_req_val  = 4'b0100;
        s_req_msg  = 16'h0A00;
        cycle();
        check("stall_load", 32'(a4_msg), 32'(6'b10_1010));
        s_recv_rdy = 1'b0;
        s_req_msg  = 16'h0B00;
        repeat (3) begin
            cycle();
            check("stall_hold", 32'(a4_msg), 32'(6'b10_1010));
            check("stall_rdy",  32'(r4_rdy), 32'(0));
        end
        s_recv_rdy = 1'b1;
        s_req_val  = 4'b0000;
        #1;
        check("stall_last", 32'(a4_msg), 32'(6'b10_1010));
        check("stall_lval", 32'(a4_val), 32'(1));
        cycle();
        check("drained", 32'(a4_val), 32'(0));

        // Return demux to lane 1, then backpressure from that lane.
        s_send_msg = 6'b01_0101;
        s_send_val = 1'b1;
        s_resp_rdy = 4'b0010;
        #1;
        check("ret_val",   32'(s4_val),  32'(4'b0010));
        check("ret_msg",   32'(s4_msg),  32'(16'h0050));
        check("ret_rdy",   32'(a4_srdy), 32'(1));
        s_resp_rdy = 4'b0000;
        #1;
        check("ret_bp",    32'(a4_srdy), 32'(0));
        cycle();

        // Unknown id on the 3-requester instance: sink and saturating count.
        s_send_msg = 6'b11_0000;
        s_send_val = 1'b1;
        s_resp_rdy = 4'hF;
        cycle();
        check("drop_first", 32'(d3), 32'(1));
        repeat (299) cycle();
        check("drop_sat",   32'(d3),      32'(255));
        check("drop_rval",  32'(s3_val),  32'(0));
        check("drop_srdy",  32'(a3_srdy), 32'(1));

        // Only req3, then req0 and req3 together: pointer wraps so req0 wins.
        s_send_val = 1'b0;
        s_req_val  = 4'b1000;
        s_recv_rdy = 1'b1;
        #1;
        check("wrap_rdy3", 32'(r4_rdy), 32'(4'b1000));
        cycle();
        check("wrap_g3",   32'(g4),     32'(3));
        s_req_val  = 4'b1001;
        #1;
        check("wrap_rdy0", 32'(r4_rdy), 32'(4'b0001));
        cycle();
        check("wrap_g0",   32'(g4),     32'(0));

        // More random traffic from a non-reset state.
        repeat (200) begin
            randomize_inputs();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
